// File: rtl/pipeline_collector.sv
// ---------------------------------------------------------------------------
// pipeline_collector
//
// Gathers a stream of WIDTH-bit words into frames of up to SIZE words and
// presents each completed frame as one wide word with a valid/ready handshake.
// A frame ends when SIZE words have been accepted or when a word arrives with
// in_last set. While a frame is held, a new word is accepted only in the same
// cycle the held frame is taken downstream.
//
// Ports
//   clk        : single clock, all state changes on its rising edge
//   rst        : synchronous, active-high reset
//   datain     : input word (WIDTH bits)
//   in_valid   : datain holds a word
//   in_last    : the word on datain closes the current frame
//   in_ready   : the block accepts a word this cycle (combinational)
//   dataout    : assembled frame, slot k at [k*WIDTH +: WIDTH], slot 0 first
//   out_len    : number of valid slots in dataout (1..SIZE)
//   out_valid  : dataout/out_len hold a complete frame
//   out_ready  : downstream takes the frame this cycle
// ---------------------------------------------------------------------------
module pipeline_collector #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      datain,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [WIDTH*SIZE-1:0] dataout,
    output logic [7:0]            out_len,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WIDTH*SIZE-1:0]   asm_q, asm_d;
    logic [WIDTH*SIZE-1:0]   dataout_q, dataout_d;
    logic [7:0]              out_len_q, out_len_d;
    logic                    out_valid_q, out_valid_d;

    logic [IDX_W-1:0]        wr_idx_s;
    logic [WIDTH*SIZE-1:0]   frame_s;
    logic                    in_xfer_s;
    logic                    out_xfer_s;
    logic                    closes_s;

    // Ready to take a word: always while collecting, only alongside a release while holding
    always_comb begin
        if (rst) begin
            in_ready = 1'b0;
        end else if (state_q == FULL) begin
            in_ready = out_ready;
        end else begin
            in_ready = 1'b1;
        end
    end

    // Handshake qualifiers; rst takes priority in the state register
    always_comb begin
        in_xfer_s  = in_valid & in_ready;
        out_xfer_s = out_valid_q & out_ready;
    end

    // Build the frame including this cycle's word; in FULL the new word starts a fresh frame at slot 0
    always_comb begin
        wr_idx_s = (state_q == FULL) ? {IDX_W{1'b0}} : idx_q;
        frame_s  = {(WIDTH*SIZE){1'b0}};
        for (int k = 0; k < SIZE; k++) begin
            if (wr_idx_s == IDX_W'(k)) begin
                frame_s[k*WIDTH +: WIDTH] = datain;
            end else if (state_q == FULL) begin
                frame_s[k*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            end else begin
                frame_s[k*WIDTH +: WIDTH] = asm_q[k*WIDTH +: WIDTH];
            end
        end
        closes_s = (wr_idx_s == IDX_W'(SIZE - 1)) | in_last;
    end

    // Next-state logic for the collector FSM and its datapath registers
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        dataout_d   = dataout_q;
        out_len_d   = out_len_q;
        out_valid_d = out_valid_q;
        if (in_xfer_s) begin
            if (closes_s) begin
                // Publish the frame and clear the assembly register for the next one
                dataout_d   = frame_s;
                out_len_d   = 8'(wr_idx_s) + 8'd1;
                out_valid_d = 1'b1;
                idx_d       = {IDX_W{1'b0}};
                asm_d       = {(WIDTH*SIZE){1'b0}};
                state_d     = FULL;
            end else begin
                // In FULL this path also releases the held frame
                asm_d       = frame_s;
                idx_d       = wr_idx_s + IDX_W'(1);
                out_valid_d = 1'b0;
                state_d     = FILL;
            end
        end else if (out_xfer_s) begin
            out_valid_d = 1'b0;
            state_d     = FILL;
        end else begin
            state_d = state_q;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            idx_q       <= {IDX_W{1'b0}};
            asm_q       <= {(WIDTH*SIZE){1'b0}};
            dataout_q   <= {(WIDTH*SIZE){1'b0}};
            out_len_q   <= 8'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            dataout_q   <= dataout_d;
            out_len_q   <= out_len_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Frame outputs come straight from registers
    always_comb begin
        dataout   = dataout_q;
        out_len   = out_len_q;
        out_valid = out_valid_q;
    end

endmodule

// File: tb/tb_pipeline_collector.sv
module tb_pipeline_collector;

    localparam int W = 16;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   datain;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [W*S-1:0] dataout;
    logic [7:0]     out_len;
    logic           out_valid;
    logic           out_ready;

    logic [W-1:0]   s1_datain;
    logic           s1_in_valid;
    logic           s1_in_last;
    logic           s1_in_ready;
    logic [W-1:0]   s1_dataout;
    logic [7:0]     s1_out_len;
    logic           s1_out_valid;
    logic           s1_out_ready;

    int nchecks = 0;
    int nerr    = 0;
    int words_acc = 0;
    int frames_out = 0;

    always #5 clk = ~clk;

    pipeline_collector #(.WIDTH(W), .SIZE(S)) u_dut (
        .clk(clk), .rst(rst), .datain(datain), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .dataout(dataout),
        .out_len(out_len), .out_valid(out_valid), .out_ready(out_ready)
    );

    pipeline_collector #(.WIDTH(W), .SIZE(1)) u_dut1 (
        .clk(clk), .rst(rst), .datain(s1_datain), .in_valid(s1_in_valid),
        .in_last(s1_in_last), .in_ready(s1_in_ready), .dataout(s1_dataout),
        .out_len(s1_out_len), .out_valid(s1_out_valid), .out_ready(s1_out_ready)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: words of the frame being collected, plus the frame on offer
    logic [W-1:0]   part[$];
    logic           exp_valid = 1'b0;
    logic [W*S-1:0] exp_data  = '0;
    int             exp_len   = 0;

    always @(negedge clk) begin
        logic exp_rdy;
        logic ix;
        logic ox;
        exp_rdy = !rst && (!exp_valid || out_ready);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) begin
            chk("dataout", 64'(dataout), 64'(exp_data));
            chk("out_len", 64'(out_len), 64'(exp_len));
        end
        ix = in_valid && exp_rdy;
        ox = exp_valid && out_ready && !rst;
        if (rst) begin
            part.delete();
            exp_valid = 1'b0;
            exp_data  = '0;
            exp_len   = 0;
        end else begin
            if (ox) begin
                exp_valid = 1'b0;
                frames_out++;
            end
            if (ix) begin
                part.push_back(datain);
                words_acc++;
                if (part.size() == S || in_last) begin
                    exp_data = '0;
                    foreach (part[k]) exp_data[k*W +: W] = part[k];
                    exp_len   = part.size();
                    exp_valid = 1'b1;
                    part.delete();
                end
            end
        end
    end

    // SIZE=1 streaming: every cycle's output is the previous cycle's word
    logic [W-1:0] s1_prev;
    logic         s1_chk = 1'b0;

    always @(posedge clk) s1_prev <= s1_datain;

    always @(negedge clk) begin
        if (s1_chk) begin
            chk("s1_out_valid", 64'(s1_out_valid), 64'd1);
            chk("s1_dataout", 64'(s1_dataout), 64'(s1_prev));
            chk("s1_out_len", 64'(s1_out_len), 64'd1);
            chk("s1_in_ready", 64'(s1_in_ready), 64'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        datain   = d;
        in_last  = last;
        while (1) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                tick();
                break;
            end
            tick();
            n++;
            if (n > 100) begin
                nchecks++;
                nerr++;
                $display("FAIL send_timeout: word %h never accepted", d);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        datain = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        s1_datain = '0; s1_in_valid = 1'b0; s1_in_last = 1'b0; s1_out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_dataout", 64'(dataout), 64'd0);
        chk("rst_out_len", 64'(out_len), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        tick();

        // Full frame back-to-back
        out_ready = 1'b1;
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        send(16'h3333, 1'b0);
        send(16'h4444, 1'b0);
        chk("full_valid", 64'(out_valid), 64'd1);
        chk("full_data", 64'(dataout), 64'h4444_3333_2222_1111);
        chk("full_len", 64'(out_len), 64'd4);
        tick();
        chk("full_consumed", 64'(out_valid), 64'd0);

        // Short frame closed by in_last
        send(16'hAAAA, 1'b0);
        send(16'hBBBB, 1'b1);
        chk("short_data", 64'(dataout), 64'h0000_0000_BBBB_AAAA);
        chk("short_len", 64'(out_len), 64'd2);
        tick();

        // Backpressure: held frame blocks input for 5 cycles
        out_ready = 1'b0;
        send(16'h0005, 1'b0);
        send(16'h0006, 1'b0);
        send(16'h0007, 1'b0);
        send(16'h0008, 1'b0);
        in_valid = 1'b1;
        datain   = 16'h0009;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_data", 64'(dataout), 64'h0008_0007_0006_0005);
            chk("bp_valid", 64'(out_valid), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        send(16'h0009, 1'b0);
        chk("bp_release", 64'(out_valid), 64'd0);
        send(16'h000A, 1'b0);
        send(16'h000B, 1'b0);
        send(16'h000C, 1'b0);
        chk("bp_slot0", 64'(dataout), 64'h000C_000B_000A_0009);

        // Release and close in the same cycle: stays valid with the new frame
        out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        send(16'h00EE, 1'b1);
        chk("swap_valid", 64'(out_valid), 64'd1);
        chk("swap_data", 64'(dataout), 64'h0000_0000_0000_00EE);
        chk("swap_len", 64'(out_len), 64'd1);
        tick();

        // Reset mid-frame discards partial words
        send(16'h0D01, 1'b0);
        send(16'h0D02, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        send(16'h0E01, 1'b0);
        send(16'h0E02, 1'b0);
        send(16'h0E03, 1'b0);
        send(16'h0E04, 1'b0);
        chk("midrst_data", 64'(dataout), 64'h0E04_0E03_0E02_0E01);
        chk("midrst_len", 64'(out_len), 64'd4);
        tick();

        // Reset while holding a frame drops it
        out_ready = 1'b0;
        send(16'h0F01, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("fullrst_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        tick();

        // SIZE=1 continuous streaming
        s1_in_valid  = 1'b1;
        s1_out_ready = 1'b1;
        s1_datain    = W'($urandom);
        tick();
        s1_chk = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s1_datain  = W'($urandom);
            s1_in_last = 1'($urandom_range(0, 1));
            tick();
        end
        s1_chk = 1'b0;
        s1_in_valid = 1'b0;
        tick();

        // Randomized traffic checked cycle by cycle against the model
        words_acc = 0;
        cyc = 0;
        while (words_acc < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            datain    = W'($urandom);
            in_last   = ($urandom_range(0, 99) < 20);
            out_ready = ($urandom_range(0, 99) < 60);
            rst       = ($urandom_range(0, 1999) == 0);
            tick();
            cyc++;
        end
        rst = 1'b0;
        in_valid = 1'b0;
        chk("random_words_done", 64'(words_acc >= 10000), 64'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/pipeline_collector.md
PIPELINE_COLLECTOR -- requirements
Module: pipeline_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning bits per input word.
REQ-002 The block SHALL have parameter SIZE, default 8, meaning words per output frame; legal range 1..255.
REQ-003 Port clk  input  1  the single clock; all state changes on posedge clk.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port datain  input  WIDTH  input word.
REQ-006 Port in_valid  input  1  datain holds a word.
REQ-007 Port in_last  input  1  qualifies the word as the final word of a frame; meaningful only when in_valid=1.
REQ-008 Port in_ready  output  1  block accepts a word this cycle.
REQ-009 Port dataout  output  WIDTH*SIZE  assembled frame; slot k occupies bits [k*WIDTH +: WIDTH]; slot 0 holds the first word received.
REQ-010 Port out_len  output  8  number of valid slots in dataout, 1..SIZE.
REQ-011 Port out_valid  output  1  dataout and out_len hold a complete frame.
REQ-012 Port out_ready  input  1  downstream accepts the frame this cycle.

Function
REQ-013 An input transfer SHALL occur on a clock edge where in_valid=1, in_ready=1 and rst=0; an output transfer SHALL occur where out_valid=1, out_ready=1 and rst=0.
REQ-014 The block SHALL use two states, FILL (collecting) and FULL (frame held), plus a write index idx of 0..SIZE-1.
REQ-015 in_ready SHALL be combinational: 0 while rst=1; otherwise 1 in FILL and equal to out_ready in FULL.
REQ-016 In FILL, an input transfer SHALL write datain into slot idx of the assembly register and increment idx.
REQ-017 In FILL, a transfer with idx=SIZE-1 or in_last=1 SHALL end the frame: on that edge dataout gets the assembled frame, out_len gets idx+1, out_valid goes to 1, idx returns to 0, and the state goes to FULL.
REQ-018 On an early end via in_last, slots idx+1..SIZE-1 of dataout SHALL be zero.
REQ-019 Frame latency SHALL be one cycle: out_valid rises on the edge that accepts the closing word.
REQ-020 In FULL, dataout, out_len and out_valid SHALL hold stable until an output transfer occurs.
REQ-021 In FULL, an output transfer with no input transfer SHALL clear out_valid and go to FILL.
REQ-022 In FULL, simultaneous output and input transfers SHALL handle the new word as in FILL with idx=0:
  - The new word is written to slot 0.
  - The held frame is released.
  - If the new word closes a frame (SIZE=1 or in_last=1), the block stays in FULL with the new frame loaded and out_valid stays at 1.
  - Otherwise the block goes to FILL with idx=1.
REQ-023 The assembly register SHALL clear to zero at the start of each frame, so unfilled slots never carry stale data.
REQ-024 in_last on a word that is not accepted SHALL have no effect.
REQ-025 The block SHALL never drop or duplicate a word; it SHALL accept no input while holding an unconsumed frame, except under REQ-022.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL set state=FILL, idx=0, assembly register=0, dataout=0, out_len=0 and out_valid=0.
REQ-027 A reset asserted mid-frame or in FULL SHALL discard partial and held data with no output transfer; the first word accepted after reset lands in slot 0.

Verification (WIDTH=16, SIZE=4 unless stated)
REQ-028 Full frame: send 0x1111, 0x2222, 0x3333, 0x4444 back-to-back with out_ready=1 -> out_valid=1 one cycle after 0x4444 is accepted, dataout=0x4444_3333_2222_1111, out_len=4.
REQ-029 Short frame: send 0xAAAA then 0xBBBB with in_last=1 -> dataout=0x0000_0000_BBBB_AAAA, out_len=2.
REQ-030 Backpressure: complete a frame with out_ready=0 for 5 cycles -> in_ready=0 and dataout stable throughout; on out_ready=1 with in_valid=1, the new word is accepted into slot 0 in the same cycle.
REQ-031 Continuous streaming at SIZE=1 with in_valid=out_ready=1 -> one frame per cycle, out_valid held at 1, dataout equals the previous cycle's datain.
REQ-032 Reset mid-frame: accept 2 words, pulse rst for 1 cycle, then send 4 words -> the frame contains only the 4 post-reset words and out_len=4.
REQ-033 Random in_valid/out_ready with randomly placed in_last over 10k words -> scoreboard matches every word, slot position and out_len.
